// File: rtl/alg_amba_vip_apb_pkg.sv
// alg_amba_vip_apb_pkg: shared FSM state type, select-width helper and error read data for the APB decoder
package alg_amba_vip_apb_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_dec_state_e;
  localparam bit APB_ERR_RDATA = 1'b0;
  function automatic int apb_sel_w(input int num_slv);
    return num_slv > 1 ? $clog2(num_slv) : 1;
  endfunction
endpackage

// File: rtl/alg_amba_vip_apb_decoder_if.sv
// alg_amba_vip_apb_decoder_if: upstream (s_*) and downstream (m_*) APB signals; slave = decoder view, master = environment view
interface alg_amba_vip_apb_decoder_if #(
  parameter int NUM_SLV = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
);
  logic                      s_psel;
  logic                      s_penable;
  logic [ADDR_W-1:0]         s_paddr;
  logic                      s_pwrite;
  logic [DATA_W-1:0]         s_pwdata;
  logic [DATA_W-1:0]         s_prdata;
  logic                      s_pready;
  logic                      s_pslverr;
  logic [NUM_SLV-1:0]        m_psel;
  logic                      m_penable;
  logic [ADDR_W-1:0]         m_paddr;
  logic                      m_pwrite;
  logic [DATA_W-1:0]         m_pwdata;
  logic [NUM_SLV*DATA_W-1:0] m_prdata;
  logic [NUM_SLV-1:0]        m_pready;
  logic [NUM_SLV-1:0]        m_pslverr;
  modport slave (
    input  s_psel, s_penable, s_paddr, s_pwrite, s_pwdata, m_prdata, m_pready, m_pslverr,
    output s_prdata, s_pready, s_pslverr, m_psel, m_penable, m_paddr, m_pwrite, m_pwdata
  );
  modport master (
    output s_psel, s_penable, s_paddr, s_pwrite, s_pwdata, m_prdata, m_pready, m_pslverr,
    input  s_prdata, s_pready, s_pslverr, m_psel, m_penable, m_paddr, m_pwrite, m_pwdata
  );
endinterface

// File: rtl/alg_amba_vip_apb_timeout_cnt.sv
// alg_amba_vip_apb_timeout_cnt: up-counter with clear/enable; o_done flags the LIMIT-th enabled cycle
module alg_amba_vip_apb_timeout_cnt #(
  parameter int LIMIT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_done
);
  localparam int W = $clog2(LIMIT);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk) begin
    if (rst || i_clr) r_cnt <= '0;
    else if (i_en) r_cnt <= r_cnt + 1'b1;
  end
  assign o_done = i_en && r_cnt == W'(LIMIT - 1);
endmodule

// File: rtl/alg_amba_vip_apb_decoder.sv
// alg_amba_vip_apb_decoder: APB 1-to-NUM_SLV address decoder with registered outputs;
// defining ALG_APB_DEC_TIMEOUT_EN abandons targets that stall for TIMEOUT_CYC ACCESS cycles
module alg_amba_vip_apb_decoder
  import alg_amba_vip_apb_pkg::*;
#(
  parameter int NUM_SLV     = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int SEL_LSB     = 12,
  parameter int TIMEOUT_CYC = 256
) (
  input logic clk,
  input logic rst,
  alg_amba_vip_apb_decoder_if.slave apb
);
  localparam int SEL_W = apb_sel_w(NUM_SLV);
  localparam int HI_W  = ADDR_W - SEL_LSB;
  apb_dec_state_e   r_state;
  logic [SEL_W-1:0] r_idx;
  logic [HI_W-1:0]  w_hi;
  logic             w_mapped;
  logic             w_rdy;
  logic             w_to;
  // All address bits above SEL_LSB form the index, so e.g. 0x5000 with 4 targets decodes as unmapped
  assign w_hi     = apb.s_paddr[ADDR_W-1:SEL_LSB];
  assign w_mapped = w_hi < HI_W'(NUM_SLV);
  assign w_rdy    = apb.m_pready[r_idx];
`ifdef ALG_APB_DEC_TIMEOUT_EN
  alg_amba_vip_apb_timeout_cnt #(.LIMIT(TIMEOUT_CYC)) u_timeout_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (r_state != ACCESS),
    .i_en   (r_state == ACCESS),
    .o_done (w_to)
  );
`else
  logic w_unused_to;
  assign w_unused_to = TIMEOUT_CYC != 0;
  assign w_to        = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_idx         <= '0;
      apb.s_prdata  <= '0;
      apb.s_pready  <= 1'b0;
      apb.s_pslverr <= 1'b0;
      apb.m_psel    <= '0;
      apb.m_penable <= 1'b0;
      apb.m_paddr   <= '0;
      apb.m_pwrite  <= 1'b0;
      apb.m_pwdata  <= '0;
    end else begin
      case (r_state)
        IDLE: if (apb.s_psel && !apb.s_penable) begin
          if (w_mapped) begin
            r_idx        <= w_hi[SEL_W-1:0];
            apb.m_psel   <= NUM_SLV'(1) << w_hi[SEL_W-1:0];
            apb.m_paddr  <= apb.s_paddr;
            apb.m_pwrite <= apb.s_pwrite;
            apb.m_pwdata <= apb.s_pwrite ? apb.s_pwdata : '0;
            r_state      <= SETUP;
          end else begin
            apb.s_pready  <= 1'b1;
            apb.s_pslverr <= 1'b1;
            apb.s_prdata  <= {DATA_W{APB_ERR_RDATA}};
            r_state       <= RESP;
          end
        end
        SETUP: begin
          apb.m_penable <= 1'b1;
          r_state       <= ACCESS;
        end
        ACCESS: if (w_rdy || w_to) begin
          apb.m_psel    <= '0;
          apb.m_penable <= 1'b0;
          apb.s_pready  <= 1'b1;
          apb.s_pslverr <= w_rdy ? apb.m_pslverr[r_idx] : 1'b1;
          apb.s_prdata  <= (w_rdy && !apb.m_pwrite) ? apb.m_prdata[int'(r_idx)*DATA_W +: DATA_W]
                                                    : {DATA_W{APB_ERR_RDATA}};
          r_state       <= RESP;
        end
        default: begin
          apb.s_pready <= 1'b0;
          r_state      <= IDLE;
        end
      endcase
    end
  end
endmodule
